wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Arbiter and sequencer for the single integer register-file write port. It accepts writeback requests from three producers: the ALU/link-address path, the load unit and the FPU-to-integer move path. It grants one per cycle by fixed priority with a starvation guard, and drives a registered write (enable, register index, data) into the register file. It replaces the purely combinational source selection in front of the write port, now that load and FPU results arrive with variable latency.

## Interface

Parameters:
- STARVE_LIMIT, 4: consecutive denied cycles after which a requester becomes urgent; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- load_valid  in  1  load unit has a result
- load_rd  in  5  destination register
- load_data  in  32  result data
- load_ready  out  1  load request accepted this cycle
- fpu_valid  in  1  FPU move-to-integer result present
- fpu_rd  in  5  destination register
- fpu_data  in  32  result data
- fpu_ready  out  1  fpu request accepted this cycle
- alu_valid  in  1  ALU or link-address result present
- alu_rd  in  5  destination register
- alu_data  in  32  result data
- alu_ready  out  1  alu request accepted this cycle
- wb_we  out  1  register-file write enable
- wb_rd  out  5  register-file write index
- wb_data  out  32  register-file write data
- wb_src  out  2  source of the current write: 0 none, 1 load, 2 fpu, 3 alu

## Operation

- Handshake: a transfer occurs when valid and ready are both high in the same cycle.
- A requester holds valid, rd and data stable until accepted. Valid never drops without a transfer, except on rst.
- Ready outputs are combinational from the valids and the urgent flags. At most one ready is high per cycle.
- Ready is never high while its valid is low or while rst is high.
- Priority:
  - Base order is load > fpu > alu.
  - If any valid requester is urgent, only urgent requesters compete, in the base order.
- Starvation counter, one per requester:
  - Increments, saturating at STARVE_LIMIT, when valid && !ready.
  - Clears to 0 on a transfer or when valid is low.
  - The requester is urgent when its counter == STARVE_LIMIT.
- The accepted request is registered: the next cycle shows wb_we=1, wb_rd=rd, wb_data=data, wb_src=source id.
- rd == 0: the request is accepted normally (ready high, counter cleared), but the next cycle shows wb_we=0, wb_rd=0, wb_data=0, wb_src=0. Register 0 is never written.
- A cycle with no transfer shows wb_we=0 and wb_src=0 next cycle. wb_rd and wb_data are 0 in that case.

## Timing

- Latency: request accepted in cycle N gives the write visible in cycle N+1 and committed at the N+1 edge. Throughput is one write per cycle; the arbiter adds no bubbles.
- Reset values: wb_we=0, wb_rd=0, wb_data=0, wb_src=0, all counters 0. All readies are 0 while rst is high.
- Reset mid-operation:
  - A request accepted in the same cycle rst is high is impossible, since ready is forced low.
  - A write already registered before rst is still presented in the cycle rst is first sampled. Outputs clear at that edge.
  - Pending requests are dropped. Producers are reset by the same rst.
- Simultaneous urgent requesters: base order applies. The losers keep their saturated counters and win on following cycles in order.
- Worst-case wait for a continuously valid requester: STARVE_LIMIT + 2 cycles.

## Structure

- Shared package (wb_pkg):
  - Source ids SRC_NONE=0, SRC_LOAD=1, SRC_FPU=2, SRC_ALU=3.
  - REG_IDX_W=5, DATA_W=32.
- Sub-module wb_starve_counter, instantiated three times.
  - Inputs: clk, rst, valid, granted.
  - Output: urgent. STARVE_LIMIT is a parameter.
  - Counter width is 4 bits.
- Top level: combinational grant logic plus the output register.

## Test plan

1. Lone request: alu_valid=1, rd=5, data=0x00001234 → alu_ready=1 same cycle. Next cycle wb_we=1, wb_rd=5, wb_data=0x00001234, wb_src=3.
2. Simultaneous request: load (rd=1), fpu (rd=2) and alu (rd=3) all valid in cycle 0 and held → readies go load, fpu, alu in cycles 0, 1, 2. Writes rd=1, 2, 3 appear in cycles 1, 2, 3 with wb_src 1, 2, 3.
3. Starvation: load valid with new data every cycle, alu held valid, STARVE_LIMIT=4 → alu denied cycles 0–3, urgent from cycle 4, alu_ready=1 in cycle 4, load_ready=0 in cycle 4.
4. Zero register: fpu_valid=1, rd=0, data=0xDEADBEEF → fpu_ready=1. Next cycle wb_we=0, wb_src=0.
5. Mid-operation reset: three requests pending, rst=1 for 2 cycles → all readies 0 while rst high. Outputs 0 from the cycle after rst is first sampled. After release, load is granted first with counters restarting from 0.
6. Idle: no valids for 10 cycles → wb_we=0, wb_rd=0, wb_data=0, wb_src=0 throughout.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and constants for the integer register-file writeback arbiter.
// Source ids double as the wb_src encoding seen by the register file.
package wb_pkg;

    localparam int REG_IDX_W = 5;
    localparam int DATA_W    = 32;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_LOAD = 2'd1,
        SRC_FPU  = 2'd2,
        SRC_ALU  = 2'd3
    } wb_src_e;

    typedef struct packed {
        logic                 we;
        logic [REG_IDX_W-1:0] rd;
        logic [DATA_W-1:0]    data;
        wb_src_e              src;
    } wb_write_t;

    // Writes to x0 are swallowed: the request completes but nothing is presented.
    function automatic wb_write_t make_write(input logic                 hit,
                                            input logic [REG_IDX_W-1:0] rd,
                                            input logic [DATA_W-1:0]    data,
                                            input wb_src_e              src);
        wb_write_t w;
        w = '0;
        if (hit && (rd != '0)) begin
            w.we   = 1'b1;
            w.rd   = rd;
            w.data = data;
            w.src  = src;
        end
        return w;
    endfunction

endpackage

// File: rtl/wb_starve_counter.sv
// Per-requester starvation counter: counts consecutive denied cycles and
// flags the requester urgent once the count saturates at STARVE_LIMIT.
module wb_starve_counter
    import wb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic valid,
    input  logic granted,
    output logic urgent
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] cnt_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p1 <= '0;
        end else if (!valid || granted) begin
            cnt_p1 <= '0;
        end else if (cnt_p1 != LIMIT) begin
            cnt_p1 <= cnt_p1 + 1'b1;
        end
    end

    assign urgent = (cnt_p1 == LIMIT);

endmodule

// File: rtl/wb_arbiter.sv
// Fixed-priority (load > fpu > alu) writeback arbiter with starvation guard,
// driving a registered write port into the integer register file.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_valid,
    input  logic [REG_IDX_W-1:0] load_rd,
    input  logic [DATA_W-1:0]    load_data,
    output logic                 load_ready,
    input  logic                 fpu_valid,
    input  logic [REG_IDX_W-1:0] fpu_rd,
    input  logic [DATA_W-1:0]    fpu_data,
    output logic                 fpu_ready,
    input  logic                 alu_valid,
    input  logic [REG_IDX_W-1:0] alu_rd,
    input  logic [DATA_W-1:0]    alu_data,
    output logic                 alu_ready,
    output logic                 wb_we,
    output logic [REG_IDX_W-1:0] wb_rd,
    output logic [DATA_W-1:0]    wb_data,
    output logic [1:0]           wb_src
);

    logic load_urgent, fpu_urgent, alu_urgent;
    logic any_urgent;
    logic load_elig, fpu_elig, alu_elig;
    wb_write_t wr_p0;
    wb_write_t wr_p1;

    wb_starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_load_cnt (
        .clk     (clk),
        .rst     (rst),
        .valid   (load_valid),
        .granted (load_ready),
        .urgent  (load_urgent)
    );

    wb_starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_fpu_cnt (
        .clk     (clk),
        .rst     (rst),
        .valid   (fpu_valid),
        .granted (fpu_ready),
        .urgent  (fpu_urgent)
    );

    wb_starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_alu_cnt (
        .clk     (clk),
        .rst     (rst),
        .valid   (alu_valid),
        .granted (alu_ready),
        .urgent  (alu_urgent)
    );

    // Stage p0: grant. When any live requester is urgent, non-urgent ones sit out.
    always_comb begin
        any_urgent = (load_valid && load_urgent) ||
                     (fpu_valid  && fpu_urgent)  ||
                     (alu_valid  && alu_urgent);
        load_elig  = load_valid && (!any_urgent || load_urgent);
        fpu_elig   = fpu_valid  && (!any_urgent || fpu_urgent);
        alu_elig   = alu_valid  && (!any_urgent || alu_urgent);

        load_ready = !rst && load_elig;
        fpu_ready  = !rst && fpu_elig && !load_elig;
        alu_ready  = !rst && alu_elig && !load_elig && !fpu_elig;
    end

    always_comb begin
        wr_p0 = '0;
        if (load_ready) begin
            wr_p0 = make_write(1'b1, load_rd, load_data, SRC_LOAD);
        end else if (fpu_ready) begin
            wr_p0 = make_write(1'b1, fpu_rd, fpu_data, SRC_FPU);
        end else if (alu_ready) begin
            wr_p0 = make_write(1'b1, alu_rd, alu_data, SRC_ALU);
        end
    end

    // Stage p1: registered write port; idle cycles present all zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_p1 <= '0;
        end else begin
            wr_p1 <= wr_p0;
        end
    end

    assign wb_we   = wr_p1.we;
    assign wb_rd   = wr_p1.rd;
    assign wb_data = wr_p1.data;
    assign wb_src  = wr_p1.src;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: grant order, starvation, x0 writes, reset, idle.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_valid, fpu_valid, alu_valid;
    logic [4:0]  load_rd, fpu_rd, alu_rd;
    logic [31:0] load_data, fpu_data, alu_data;
    logic        load_ready, fpu_ready, alu_ready;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [1:0]  wb_src;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_rd    (load_rd),
        .load_data  (load_data),
        .load_ready (load_ready),
        .fpu_valid  (fpu_valid),
        .fpu_rd     (fpu_rd),
        .fpu_data   (fpu_data),
        .fpu_ready  (fpu_ready),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .wb_we      (wb_we),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .wb_src     (wb_src)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_rdy(input string tag, input logic l, input logic f, input logic a);
        chk({tag, ".rdy"}, {29'd0, load_ready, fpu_ready, alu_ready}, {29'd0, l, f, a});
    endtask

    task automatic chk_wb(input string tag, input logic we, input logic [4:0] rd,
                          input logic [31:0] data, input logic [1:0] src);
        chk({tag, ".we"},   {31'd0, wb_we},  {31'd0, we});
        chk({tag, ".rd"},   {27'd0, wb_rd},  {27'd0, rd});
        chk({tag, ".data"}, wb_data,         data);
        chk({tag, ".src"},  {30'd0, wb_src}, {30'd0, src});
    endtask

    initial begin
        rst = 1'b1;
        load_valid = 0; fpu_valid = 0; alu_valid = 0;
        load_rd = 0; fpu_rd = 0; alu_rd = 0;
        load_data = 0; fpu_data = 0; alu_data = 0;

        // Reset state
        repeat (2) @(negedge clk);
        #1 chk_wb("reset", 0, 0, 0, 0);
        chk_rdy("reset", 0, 0, 0);
        @(negedge clk) rst = 1'b0;

        // 1. Lone ALU request
        @(negedge clk);
        alu_valid = 1; alu_rd = 5; alu_data = 32'h0000_1234;
        #1 chk_rdy("lone", 0, 0, 1);
        @(negedge clk) alu_valid = 0;
        #1 chk_wb("lone", 1, 5, 32'h0000_1234, 3);
        chk_rdy("lone.after", 0, 0, 0);

        // 2. Simultaneous requests drain in base order
        @(negedge clk);
        load_valid = 1; load_rd = 1; load_data = 32'h1111_1111;
        fpu_valid  = 1; fpu_rd  = 2; fpu_data  = 32'h2222_2222;
        alu_valid  = 1; alu_rd  = 3; alu_data  = 32'h3333_3333;
        #1 chk_rdy("simul.c0", 1, 0, 0);
        @(negedge clk) load_valid = 0;
        #1 chk_rdy("simul.c1", 0, 1, 0);
        chk_wb("simul.c1", 1, 1, 32'h1111_1111, 1);
        @(negedge clk) fpu_valid = 0;
        #1 chk_rdy("simul.c2", 0, 0, 1);
        chk_wb("simul.c2", 1, 2, 32'h2222_2222, 2);
        @(negedge clk) alu_valid = 0;
        #1 chk_rdy("simul.c3", 0, 0, 0);
        chk_wb("simul.c3", 1, 3, 32'h3333_3333, 3);

        // 3. Starvation: ALU denied 4 cycles, then wins over streaming load
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            load_valid = 1; load_rd = 5'(8 + i); load_data = 32'h100 + i;
            alu_valid  = 1; alu_rd  = 7;         alu_data  = 32'hA5A5_A5A5;
            #1;
            if (i < 4) chk_rdy("starve.denied", 1, 0, 0);
            else       chk_rdy("starve.urgent", 0, 0, 1);
            if (i > 0) chk_wb("starve.load", 1, 5'(7 + i), 32'h100 + i - 1, 1);
        end
        @(negedge clk) alu_valid = 0;
        #1 chk_rdy("starve.resume", 1, 0, 0);
        chk_wb("starve.alu", 1, 7, 32'hA5A5_A5A5, 3);
        @(negedge clk) load_valid = 0;
        #1 chk_wb("starve.load4", 1, 12, 32'h104, 1);

        // 4. Register 0 is accepted but never written
        @(negedge clk);
        fpu_valid = 1; fpu_rd = 0; fpu_data = 32'hDEAD_BEEF;
        #1 chk_rdy("zero", 0, 1, 0);
        @(negedge clk) fpu_valid = 0;
        #1 chk_wb("zero", 0, 0, 0, 0);

        // 5. Mid-operation reset; counters must restart from zero
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            load_valid = 1; load_rd = 5'(20 + i); load_data = 32'h300 + i;
            fpu_valid  = 1; fpu_rd  = 2;          fpu_data  = 32'hF0F0_F0F0;
            alu_valid  = 1; alu_rd  = 3;          alu_data  = 32'h0A0A_0A0A;
            #1 chk_rdy("prerst", 1, 0, 0);
        end
        @(negedge clk);
        rst = 1; load_rd = 23; load_data = 32'h303;
        #1 chk_rdy("rst.c0", 0, 0, 0);
        chk_wb("rst.c0", 1, 22, 32'h302, 1);
        @(negedge clk);
        #1 chk_rdy("rst.c1", 0, 0, 0);
        chk_wb("rst.c1", 0, 0, 0, 0);
        @(negedge clk) rst = 0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            if (i < 4) begin
                load_rd = 5'(24 + i); load_data = 32'h400 + i;
            end
            if (i == 5) fpu_valid = 0;
            #1;
            if (i < 4)       chk_rdy("postrst.load", 1, 0, 0);
            else if (i == 4) chk_rdy("postrst.fpu", 0, 1, 0);
            else             chk_rdy("postrst.alu", 0, 0, 1);
            if (i == 0) chk_wb("postrst.c0", 0, 0, 0, 0);
            if (i == 5) chk_wb("postrst.fpuwr", 1, 2, 32'hF0F0_F0F0, 2);
        end
        @(negedge clk);
        load_valid = 0; alu_valid = 0;
        #1 chk_rdy("postrst.end", 0, 0, 0);
        chk_wb("postrst.aluwr", 1, 3, 32'h0A0A_0A0A, 3);

        // 6. Idle
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1 chk_wb("idle", 0, 0, 0, 0);
            chk_rdy("idle", 0, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
